// File: rtl/lookup_cfg_writer.sv
// Configuration packet writer for one lookup stage: assembles TCAM entries/masks
// from multi-beat control packets and issues single-cycle TCAM / action-RAM writes.
module lookup_cfg_writer #(
    parameter int STAGE               = 0,
    parameter int C_S_AXIS_DATA_WIDTH = 256
) (
    input  logic                           axis_clk,
    input  logic                           aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                           s_axis_tvalid,
    input  logic                           s_axis_tlast,
    output logic                           s_axis_tready,
    output logic [1023:0]                  lookup_din,
    output logic [1023:0]                  lookup_din_mask,
    output logic [3:0]                     lookup_din_addr,
    output logic                           lookup_din_en,
    output logic [24:0]                    action_data_in,
    output logic [3:0]                     action_addr,
    output logic                           action_en,
    output logic [7:0]                     err_cnt
);

    localparam int         W        = C_S_AXIS_DATA_WIDTH;
    localparam int         ENTRY_W  = 1024;
    localparam logic [3:0] STAGE_ID = 4'(STAGE);
    localparam logic [7:0] OP_KEY   = 8'h01;
    localparam logic [7:0] OP_ACT   = 8'h02;

    typedef enum logic [2:0] {
        S_HDR,
        S_KEY,
        S_MASK,
        S_COMMIT,
        S_ACT,
        S_DRAIN
    } state_t;

    state_t             state;
    logic [1:0]         beat_cnt;
    logic [3:0]         addr_buf;
    logic [ENTRY_W-1:0] key_buf;
    logic [ENTRY_W-1:0] mask_buf;

    logic       beat;
    logic [7:0] hdr_op;
    logic [3:0] hdr_stage;
    logic [3:0] hdr_addr;
    logic       stage_hit;

    assign beat      = s_axis_tvalid && s_axis_tready;
    assign hdr_op    = s_axis_tdata[W-1 -: 8];
    assign hdr_stage = s_axis_tdata[W-9 -: 4];
    assign hdr_addr  = s_axis_tdata[W-13 -: 4];
    assign stage_hit = (hdr_stage == STAGE_ID);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Staging buffers shift MSB-first so the first payload beat ends up on top.
    // They are copied to the outputs only on a good commit, so bad packets leave
    // the table-facing outputs untouched.
    always_ff @(posedge axis_clk) begin
        if (beat && state == S_KEY)
            key_buf <= {key_buf[ENTRY_W-W-1:0], s_axis_tdata};
        if (beat && state == S_MASK)
            mask_buf <= {mask_buf[ENTRY_W-W-1:0], s_axis_tdata};
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            state           <= S_HDR;
            beat_cnt        <= 2'd0;
            addr_buf        <= 4'd0;
            s_axis_tready   <= 1'b0;
            lookup_din      <= '0;
            lookup_din_mask <= '0;
            lookup_din_addr <= 4'd0;
            lookup_din_en   <= 1'b0;
            action_data_in  <= 25'd0;
            action_addr     <= 4'd0;
            action_en       <= 1'b0;
            err_cnt         <= 8'd0;
        end else begin
            s_axis_tready <= 1'b1;
            lookup_din_en <= 1'b0;
            action_en     <= 1'b0;
            case (state)
                S_HDR: begin
                    if (beat) begin
                        if (!stage_hit) begin
                            // Foreign packets are skipped silently.
                            state <= s_axis_tlast ? S_HDR : S_DRAIN;
                        end else if (hdr_op == OP_KEY && !s_axis_tlast) begin
                            state    <= S_KEY;
                            beat_cnt <= 2'd0;
                            addr_buf <= hdr_addr;
                        end else if (hdr_op == OP_ACT && s_axis_tlast) begin
                            state          <= S_ACT;
                            action_en      <= 1'b1;
                            action_addr    <= hdr_addr;
                            action_data_in <= s_axis_tdata[24:0];
                            s_axis_tready  <= 1'b0;
                        end else begin
                            err_cnt <= sat_inc(err_cnt);
                            state   <= s_axis_tlast ? S_HDR : S_DRAIN;
                        end
                    end
                end
                S_KEY: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 2'd1;
                        if (s_axis_tlast) begin
                            err_cnt <= sat_inc(err_cnt);
                            state   <= S_HDR;
                        end else if (beat_cnt == 2'd3) begin
                            state    <= S_MASK;
                            beat_cnt <= 2'd0;
                        end
                    end
                end
                S_MASK: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 2'd1;
                        if (beat_cnt == 2'd3) begin
                            if (s_axis_tlast) begin
                                state           <= S_COMMIT;
                                lookup_din      <= key_buf;
                                lookup_din_mask <= {mask_buf[ENTRY_W-W-1:0], s_axis_tdata};
                                lookup_din_addr <= addr_buf;
                                lookup_din_en   <= 1'b1;
                                s_axis_tready   <= 1'b0;
                            end else begin
                                err_cnt <= sat_inc(err_cnt);
                                state   <= S_DRAIN;
                            end
                        end else if (s_axis_tlast) begin
                            err_cnt <= sat_inc(err_cnt);
                            state   <= S_HDR;
                        end
                    end
                end
                S_COMMIT: state <= S_HDR;
                S_ACT:    state <= S_HDR;
                S_DRAIN: begin
                    if (beat && s_axis_tlast)
                        state <= S_HDR;
                end
                default:  state <= S_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_lookup_cfg_writer.sv
// Directed bench for lookup_cfg_writer: a packet table plus hand-written
// sequences for stage filtering, backpressure, error saturation and mid-packet reset.
module tb_lookup_cfg_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         aresetn;
    logic [255:0] tdata;
    logic         tlast;
    logic         tvalid0, tvalid1;

    logic          rdy0, rdy1;
    logic [1023:0] din0, din1, mask0, mask1;
    logic [3:0]    kaddr0, kaddr1, aaddr0, aaddr1;
    logic          ken0, ken1, aen0, aen1;
    logic [24:0]   adata0, adata1;
    logic [7:0]    err0, err1;

    lookup_cfg_writer #(.STAGE(0), .C_S_AXIS_DATA_WIDTH(256)) dut0 (
        .axis_clk(clk), .aresetn(aresetn),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid0), .s_axis_tlast(tlast),
        .s_axis_tready(rdy0),
        .lookup_din(din0), .lookup_din_mask(mask0), .lookup_din_addr(kaddr0),
        .lookup_din_en(ken0), .action_data_in(adata0), .action_addr(aaddr0),
        .action_en(aen0), .err_cnt(err0)
    );

    lookup_cfg_writer #(.STAGE(1), .C_S_AXIS_DATA_WIDTH(256)) dut1 (
        .axis_clk(clk), .aresetn(aresetn),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid1), .s_axis_tlast(tlast),
        .s_axis_tready(rdy1),
        .lookup_din(din1), .lookup_din_mask(mask1), .lookup_din_addr(kaddr1),
        .lookup_din_en(ken1), .action_data_in(adata1), .action_addr(aaddr1),
        .action_en(aen1), .err_cnt(err1)
    );

    typedef struct {
        logic [7:0]  op;
        logic [3:0]  stage;
        logic [3:0]  addr;
        logic [24:0] action;
        int          nbeats;
        logic [3:0]  key_nib;
        logic [31:0] mask_word;
        logic [31:0] mask_step;
        bit          exp_key;
        bit          exp_act;
        bit          exp_err;
    } pkt_t;

    int errors = 0;
    int checks = 0;
    int kp0 = 0, ap0 = 0, kp1 = 0, ap1 = 0, overlap = 0;

    logic [1023:0] last_din, last_mask;
    logic [3:0]    last_kaddr, last_aaddr;
    logic [24:0]   last_adata;
    int            exp_err;

    pkt_t tbl[13];
    pkt_t p;
    int   kb, ab;

    always @(negedge clk) begin
        if (ken0) kp0++;
        if (aen0) ap0++;
        if (ken1) kp1++;
        if (aen1) ap1++;
        if ((ken0 && aen0) || (ken1 && aen1)) overlap++;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [255:0] beat_data(input pkt_t pk, input int b);
        logic [3:0]  nib;
        logic [31:0] mw;
        if (b == 0)
            return {pk.op, pk.stage, pk.addr, 215'd0, pk.action};
        if (b <= 4) begin
            nib = pk.key_nib + 4'(b - 1);
            return {64{nib}};
        end
        mw = pk.mask_word + pk.mask_step * 32'(b - 5);
        return {8{mw}};
    endfunction

    // Drives up to max_beats beats of a packet to one DUT; returns just after
    // the handshake edge of the last beat driven.
    task automatic send(input int sel, input pkt_t pk, input int max_beats, input bit gaps);
        int n;
        bit r, done;
        n = (pk.nbeats < max_beats) ? pk.nbeats : max_beats;
        for (int b = 0; b < n; b++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                tvalid0 = 1'b0;
                tvalid1 = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            tdata = beat_data(pk, b);
            tlast = (b == pk.nbeats - 1);
            if (sel == 0) tvalid0 = 1'b1;
            else          tvalid1 = 1'b1;
            done = 1'b0;
            for (int t = 0; t < 100 && !done; t++) begin
                @(negedge clk);
                r = (sel == 0) ? rdy0 : rdy1;
                @(posedge clk);
                #1;
                if (r) done = 1'b1;
            end
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL send_timeout got=stalled exp=accepted");
                tvalid0 = 1'b0;
                tvalid1 = 1'b0;
                return;
            end
        end
        tvalid0 = 1'b0;
        tvalid1 = 1'b0;
        tlast   = 1'b0;
    endtask

    task automatic verify0(input string tag, input pkt_t pk);
        int kb0, ab0;
        kb0 = kp0;
        ab0 = ap0;
        chk({tag, ".key_en_now"}, 32'(ken0), 32'(pk.exp_key));
        chk({tag, ".act_en_now"}, 32'(aen0), 32'(pk.exp_act));
        chk({tag, ".tready_now"}, 32'(rdy0), 32'(!(pk.exp_key || pk.exp_act)));
        if (pk.exp_key) begin
            last_din   = {beat_data(pk, 1), beat_data(pk, 2), beat_data(pk, 3), beat_data(pk, 4)};
            last_mask  = {beat_data(pk, 5), beat_data(pk, 6), beat_data(pk, 7), beat_data(pk, 8)};
            last_kaddr = pk.addr;
        end
        if (pk.exp_act) begin
            last_aaddr = pk.addr;
            last_adata = pk.action;
        end
        if (pk.exp_err) exp_err++;
        repeat (3) @(posedge clk);
        #1;
        chk({tag, ".key_pulses"}, 32'(kp0 - kb0), 32'(pk.exp_key));
        chk({tag, ".act_pulses"}, 32'(ap0 - ab0), 32'(pk.exp_act));
        chk({tag, ".err_cnt"}, 32'(err0), 32'(exp_err));
        chk({tag, ".tready_idle"}, 32'(rdy0), 32'd1);
        for (int q = 0; q < 4; q++) begin
            chkw($sformatf("%s.din%0d", tag, q), din0[q*256 +: 256], last_din[q*256 +: 256]);
            chkw($sformatf("%s.mask%0d", tag, q), mask0[q*256 +: 256], last_mask[q*256 +: 256]);
        end
        chk({tag, ".key_addr"}, 32'(kaddr0), 32'(last_kaddr));
        chk({tag, ".act_addr"}, 32'(aaddr0), 32'(last_aaddr));
        chk({tag, ".act_data"}, 32'(adata0), 32'(last_adata));
    endtask

    initial begin
        //          op     stg   addr   action          n  nib   mask_word      step           k  a  e
        tbl[0]  = '{8'h01, 4'd0, 4'd5,  25'd0,          9, 4'hA, 32'hFFFFFFFF,  32'd0,         1, 0, 0};
        tbl[1]  = '{8'h02, 4'd0, 4'd3,  25'h000003F,    1, 4'h0, 32'd0,         32'd0,         0, 1, 0};
        tbl[2]  = '{8'h01, 4'd2, 4'd8,  25'd0,          9, 4'h3, 32'h0,         32'd0,         0, 0, 0};
        tbl[3]  = '{8'h02, 4'd0, 4'd9,  25'h1ABCDEF,    1, 4'h0, 32'd0,         32'd0,         0, 1, 0};
        tbl[4]  = '{8'h01, 4'd0, 4'd4,  25'd0,          4, 4'h6, 32'h0,         32'd0,         0, 0, 1};
        tbl[5]  = '{8'h01, 4'd0, 4'd12, 25'd0,          9, 4'h1, 32'h0F0F0F0F,  32'd1,         1, 0, 0};
        tbl[6]  = '{8'h01, 4'd0, 4'd2,  25'd0,         10, 4'h8, 32'hDEADBEEF,  32'd0,         0, 0, 1};
        tbl[7]  = '{8'h7F, 4'd0, 4'd1,  25'd0,          3, 4'h2, 32'h0,         32'd0,         0, 0, 1};
        tbl[8]  = '{8'h01, 4'd0, 4'd1,  25'd0,          1, 4'h0, 32'h0,         32'd0,         0, 0, 1};
        tbl[9]  = '{8'h02, 4'd0, 4'd6,  25'h0000005,    2, 4'h0, 32'h0,         32'd0,         0, 0, 1};
        tbl[10] = '{8'h01, 4'd0, 4'd7,  25'd0,          7, 4'h9, 32'h11111111,  32'd0,         0, 0, 1};
        tbl[11] = '{8'h02, 4'd3, 4'd10, 25'h0000077,    1, 4'h0, 32'h0,         32'd0,         0, 0, 0};
        tbl[12] = '{8'h01, 4'd0, 4'd15, 25'd0,          9, 4'h5, 32'h12345678,  32'h11111111,  1, 0, 0};

        aresetn = 1'b0;
        tdata   = '0;
        tlast   = 1'b0;
        tvalid0 = 1'b0;
        tvalid1 = 1'b0;
        last_din   = '0;
        last_mask  = '0;
        last_kaddr = 4'd0;
        last_aaddr = 4'd0;
        last_adata = 25'd0;
        exp_err    = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.tready", 32'(rdy0), 32'd0);
        chk("rst.key_en", 32'(ken0), 32'd0);
        chk("rst.act_en", 32'(aen0), 32'd0);
        chk("rst.err_cnt", 32'(err0), 32'd0);
        chkw("rst.din0", din0[255:0], 256'd0);
        chkw("rst.mask3", mask0[1023:768], 256'd0);
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.tready_after_release", 32'(rdy0), 32'd1);

        for (int i = 0; i < 13; i++) begin
            send(0, tbl[i], 100, 1'b0);
            verify0($sformatf("vec%0d", i), tbl[i]);
        end

        // Stage filter on the STAGE=1 instance, then a normal action write.
        p = '{8'h01, 4'd2, 4'd4, 25'd0, 9, 4'hC, 32'hFFFF0000, 32'd0, 0, 0, 0};
        send(1, p, 100, 1'b0);
        chk("stg.key_en_now", 32'(ken1), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("stg.key_pulses", 32'(kp1), 32'd0);
        chk("stg.err_cnt", 32'(err1), 32'd0);
        chk("stg.tready", 32'(rdy1), 32'd1);
        p = '{8'h02, 4'd1, 4'd7, 25'h0000155, 1, 4'h0, 32'd0, 32'd0, 0, 1, 0};
        send(1, p, 100, 1'b0);
        chk("stg.act_en_now", 32'(aen1), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("stg.act_pulses", 32'(ap1), 32'd1);
        chk("stg.act_addr", 32'(aaddr1), 32'd7);
        chk("stg.act_data", 32'(adata1), 32'h155);
        chk("stg.err_after", 32'(err1), 32'd0);

        // Key write with random tvalid gaps.
        p = '{8'h01, 4'd0, 4'd6, 25'd0, 9, 4'h7, 32'hA5A5A5A5, 32'd3, 1, 0, 0};
        send(0, p, 100, 1'b1);
        verify0("gaps", p);

        // Error counter saturation.
        p = '{8'h7F, 4'd0, 4'd0, 25'd0, 1, 4'h0, 32'd0, 32'd0, 0, 0, 1};
        kb = kp0;
        ab = ap0;
        for (int i = 0; i < 300; i++) send(0, p, 100, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("sat.err_cnt", 32'(err0), 32'hFF);
        chk("sat.no_strobes", 32'((kp0 - kb) + (ap0 - ab)), 32'd0);

        // Reset after the 6th beat of a key packet.
        p = '{8'h01, 4'd0, 4'd11, 25'd0, 9, 4'h2, 32'hCAFEF00D, 32'd0, 1, 0, 0};
        kb = kp0;
        send(0, p, 6, 1'b0);
        aresetn = 1'b0;
        #1;
        chk("mrst.tready", 32'(rdy0), 32'd0);
        chk("mrst.err_cnt", 32'(err0), 32'd0);
        chk("mrst.key_addr", 32'(kaddr0), 32'd0);
        chk("mrst.act_addr", 32'(aaddr0), 32'd0);
        chk("mrst.act_data", 32'(adata0), 32'd0);
        for (int q = 0; q < 4; q++) begin
            chkw($sformatf("mrst.din%0d", q), din0[q*256 +: 256], 256'd0);
            chkw($sformatf("mrst.mask%0d", q), mask0[q*256 +: 256], 256'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst.tready_release", 32'(rdy0), 32'd1);
        chk("mrst.no_key_pulse", 32'(kp0 - kb), 32'd0);
        last_din   = '0;
        last_mask  = '0;
        last_kaddr = 4'd0;
        last_aaddr = 4'd0;
        last_adata = 25'd0;
        exp_err    = 0;
        p = '{8'h02, 4'd0, 4'd13, 25'h0ABCDE0, 1, 4'h0, 32'd0, 32'd0, 0, 1, 0};
        send(0, p, 100, 1'b0);
        verify0("post_rst", p);

        chk("no_overlap", 32'(overlap), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lookup_cfg_writer.md
# lookup_cfg_writer

Control-path writer for one pipeline stage's lookup engine: consumes configuration packets from a 256-bit AXI-Stream control channel and drives the lookup engine's TCAM write port (entry, mask, address, enable) and action-RAM write port. It assembles 1024-bit key entries and masks from multi-beat packets and filters packets by stage ID. It drains malformed or foreign packets and counts errors, so a bad packet never produces a partial table write.

## Interface
- STAGE, 0: stage ID this instance owns; compared with header field stage_id.
- C_S_AXIS_DATA_WIDTH, 256: control stream width; fixed at 256, other values unsupported.
- axis_clk  in  1  single clock for all logic.
- aresetn  in  1  reset, asynchronous, active-low.
- s_axis_tdata  in  256  control beat.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tlast  in  1  last beat of packet.
- s_axis_tready  out  1  beat accepted when tvalid && tready.
- lookup_din  out  1024  TCAM entry data.
- lookup_din_mask  out  1024  TCAM entry mask.
- lookup_din_addr  out  4  TCAM entry index.
- lookup_din_en  out  1  one-cycle TCAM write strobe.
- action_data_in  out  25  action word.
- action_addr  out  4  action RAM index.
- action_en  out  1  one-cycle action RAM write strobe.
- err_cnt  out  8  saturating count of malformed packets.

## Operation
- Header beat (first beat of every packet): opcode = tdata[255:248], stage_id = tdata[247:244], addr = tdata[243:240], action = tdata[24:0].
- Opcode 0x01 (key write): packet length is 9 beats: header, 4 key beats, then 4 mask beats. tlast is set on the 9th beat only.
  - Key beats fill lookup_din MSB-first: beat 1 fills [1023:768] and beat 4 fills [255:0].
  - Mask beats fill lookup_din_mask in the same order.
- Opcode 0x02 (action write): single-beat packet with tlast set on the header beat.
- States:
  - HDR: decode the header.
    - 0x01 with stage match and !tlast -> KEY, beat counter cleared.
    - 0x02 with stage match and tlast -> ACT.
    - Stage mismatch: if tlast, stay in HDR; else go to DRAIN. No error is counted.
    - Unknown opcode, or length mismatch (0x01 with tlast, or 0x02 without tlast): error; go to DRAIN if !tlast, else stay in HDR.
  - KEY: on each accepted beat, store it and increment the 2-bit counter.
    - tlast before the 4th key beat -> error, return to HDR, no write.
    - After the 4th beat -> MASK, counter cleared.
  - MASK: same storage rule, filling the mask.
    - 4th beat with tlast -> COMMIT.
    - tlast earlier -> error, return to HDR.
    - 4th beat without tlast -> error, go to DRAIN, no write.
  - COMMIT: pulse lookup_din_en for one cycle with lookup_din_addr = latched addr, then return to HDR.
  - ACT: pulse action_en for one cycle with action_data_in and action_addr latched from the header, then return to HDR.
  - DRAIN: accept beats until tlast, then return to HDR. No write occurs.
- s_axis_tready = 1 in HDR, KEY, MASK and DRAIN; 0 in COMMIT and ACT.
- err_cnt increments by 1 per malformed packet and saturates at 0xFF (no wrap).
- lookup_din, lookup_din_mask, lookup_din_addr, action_data_in and action_addr hold their last values between strobes.

## Timing
- Reset values: all outputs 0. s_axis_tready = 0 during reset and 1 from the first clock edge after release (state HDR).
- Key-write latency: lookup_din_en is high in the cycle immediately after the 9th beat's handshake edge. Data, mask and addr are stable in that cycle and are not modified until the next packet.
- Action-write latency: action_en is high in the cycle after the header handshake.
- Back-to-back: the cycle after COMMIT or ACT, tready = 1 again. Maximum throughput is one key write per 10 cycles and one action write per 2 cycles.
- tvalid low mid-packet: the state and beat counter hold; there is no timeout.
- A bad packet never asserts lookup_din_en or action_en.
- Reset asserted mid-packet: the partial entry is discarded, no strobe is issued, and after release the next beat is treated as a header (the upstream sender is also reset).
- Strobes never overlap; at most one of lookup_din_en and action_en is high in any cycle.

## Test plan
- Key write, STAGE=0: header 0x01/stage 0/addr 5, key beats 0xA..., 0xB..., 0xC..., 0xD..., mask beats all-ones -> exactly one lookup_din_en pulse, addr=5, lookup_din={A,B,C,D} beats, mask all-ones, one cycle after the 9th beat.
- Action write: single beat, opcode 0x02, addr 3, action 0x000003f, tlast -> action_en pulse with action_addr=3 and action_data_in=0x3f the next cycle; err_cnt=0.
- Stage filter: STAGE=1, 9-beat key packet with stage_id 2 -> all beats accepted, no strobe, err_cnt unchanged. An immediately following valid action packet writes normally.
- Truncated key packet: tlast on the 3rd key beat -> no strobe, err_cnt=1, and the next valid packet succeeds.
- Overlong and unknown-opcode packets: a 10-beat 0x01 packet and a 3-beat opcode 0x7F packet -> both drained, no strobes, err_cnt=2. A loop of 300 bad packets leaves err_cnt=0xFF.
- Backpressure and reset: random tvalid gaps during a key packet still give a correct single write. Asserting aresetn low after the 6th beat gives no strobe, and all outputs read 0 after reset.
